park_slot_sensor_filter: RTL and testbench

- Upstream stage of the parking-lot indicator.
- Takes raw, asynchronous, bouncy per-slot occupancy sensors and synchronises and debounces each one.
- Produces the stable occupancy vector that drives the indicator's SW input, plus per-slot arrive/depart event pulses and a free-slot count.
- Runs on the board clock; one instance per lot.

---
 rtl/park_pkg.sv | 15 +
 rtl/park_slot_debounce.sv | 151 +++++++++++++++
 rtl/park_slot_sensor_filter.sv | 56 +++++
 tb/tb_park_slot_sensor_filter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared constants and types for the parking-lot sensor front end.
package park_pkg;

  localparam int PARK_NUM_SLOTS      = 6;
  localparam int PARK_DEBOUNCE_50MHZ = 500000;
  localparam int PARK_COUNT_W        = 4;
  localparam int PARK_CHATTER_LIMIT  = 8;
  localparam int PARK_ABORT_W        = 4;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } slot_state_t;

endpackage

// File: rtl/park_slot_debounce.sv
// One parking slot: 2-FF synchroniser, debounce counter, commit/abort FSM,
// arrive/depart pulses and, when CHATTER_FAULT_EN is defined, a saturating
// abort counter that raises a sticky chatter fault.
//
// state      | meaning
// ST_STABLE  | synchronised sensor agrees with the committed occupancy
// ST_PENDING | synchronised sensor disagrees; counting toward a commit
module park_slot_debounce
  import park_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PARK_DEBOUNCE_50MHZ
`ifdef CHATTER_FAULT_EN
  ,
  parameter int CHATTER_LIMIT = PARK_CHATTER_LIMIT
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sensor,
  output logic o_occupied,
  output logic o_arrive,
  output logic o_depart,
  output logic o_fault
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  slot_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_occ;
  logic             r_arrive;
  logic             r_depart;

  slot_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_occ_nxt;
  logic             w_arrive_nxt;
  logic             w_depart_nxt;
  logic             w_commit;
  logic             w_abort;

  // Bring the asynchronous sensor into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sensor;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state, counter, committed occupancy and event pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_STABLE;
      r_cnt    <= '0;
      r_occ    <= 1'b0;
      r_arrive <= 1'b0;
      r_depart <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_occ    <= w_occ_nxt;
      r_arrive <= w_arrive_nxt;
      r_depart <= w_depart_nxt;
    end
  end

  // Next-state: commit after DEBOUNCE_CYCLES pending edges, abort on return.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_occ_nxt    = r_occ;
    w_arrive_nxt = 1'b0;
    w_depart_nxt = 1'b0;
    w_commit     = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      ST_STABLE: begin
        w_cnt_nxt = '0;
        if (r_sync2 != r_occ) begin
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (r_sync2 == r_occ) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = ST_STABLE;
          w_cnt_nxt    = '0;
          w_occ_nxt    = ~r_occ;
          w_arrive_nxt = ~r_occ;
          w_depart_nxt = r_occ;
          w_commit     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef CHATTER_FAULT_EN
  localparam logic [PARK_ABORT_W-1:0] ABORT_MAX   = '1;
  localparam logic [PARK_ABORT_W-1:0] ABORT_LIMIT = PARK_ABORT_W'(CHATTER_LIMIT);

  logic [PARK_ABORT_W-1:0] r_abort_cnt;
  logic                    r_fault;
  logic [PARK_ABORT_W-1:0] w_abort_inc;

  // Saturating increment so a long-chattering sensor never wraps back to 0.
  always_comb begin
    w_abort_inc = (r_abort_cnt == ABORT_MAX) ? r_abort_cnt : r_abort_cnt + 1'b1;
  end

  // Count aborted attempts; the fault stays set until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_abort_cnt <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (w_commit) begin
        r_abort_cnt <= '0;
      end else if (w_abort) begin
        r_abort_cnt <= w_abort_inc;
        if (w_abort_inc >= ABORT_LIMIT) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
`endif

  assign o_occupied = r_occ;
  assign o_arrive   = r_arrive;
  assign o_depart   = r_depart;

endmodule

// File: rtl/park_slot_sensor_filter.sv
// Parking-lot sensor front end: one debouncer per slot plus the free-slot
// count. Optional chatter fault detection is enabled by CHATTER_FAULT_EN.
module park_slot_sensor_filter
  import park_pkg::*;
#(
  parameter int NUM_SLOTS       = PARK_NUM_SLOTS,
  parameter int DEBOUNCE_CYCLES = PARK_DEBOUNCE_50MHZ,
  parameter int CHATTER_LIMIT   = PARK_CHATTER_LIMIT
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [NUM_SLOTS-1:0]    SENSOR,
  output logic [NUM_SLOTS-1:0]    OCCUPIED,
  output logic [NUM_SLOTS-1:0]    ARRIVE,
  output logic [NUM_SLOTS-1:0]    DEPART,
  output logic [PARK_COUNT_W-1:0] FREE_COUNT,
  output logic [NUM_SLOTS-1:0]    FAULT
);

  // The free count must fit one hex digit and the abort counter is 4 bits.
  if (NUM_SLOTS < 1 || NUM_SLOTS > 15 || DEBOUNCE_CYCLES < 1 ||
      CHATTER_LIMIT < 1 || CHATTER_LIMIT > 15) begin : g_bad_param
    $error("park_slot_sensor_filter: parameter out of range");
  end

  logic [PARK_COUNT_W-1:0] w_free;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    park_slot_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef CHATTER_FAULT_EN
      ,
      .CHATTER_LIMIT   (CHATTER_LIMIT)
`endif
    ) u_slot (
      .i_clk      (CLOCK_50),
      .i_rst      (RESET),
      .i_sensor   (SENSOR[i]),
      .o_occupied (OCCUPIED[i]),
      .o_arrive   (ARRIVE[i]),
      .o_depart   (DEPART[i]),
      .o_fault    (FAULT[i])
    );
  end

  // Free slots counted straight from the registered occupancy, so no skew.
  always_comb begin
    w_free = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_free = w_free + (OCCUPIED[i] ? 4'd0 : 4'd1);
    end
  end

  assign FREE_COUNT = w_free;

endmodule

// File: tb/tb_park_slot_sensor_filter.sv
// Bench for park_slot_sensor_filter (DEBOUNCE_CYCLES=4, CHATTER_LIMIT=3).
// Stimulus pushes the expected post-edge outputs into a queue; a monitor
// pops one entry after every clock edge and compares.
module tb_park_slot_sensor_filter;

  localparam int N     = 6;
  localparam int DEB   = 4;
  localparam int LIMIT = 3;

  typedef struct {
    logic [N-1:0] occ;
    logic [N-1:0] arr;
    logic [N-1:0] dep;
    logic [3:0]   free;
    logic [N-1:0] fault;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sensor;
  logic [N-1:0] OCCUPIED, ARRIVE, DEPART, FAULT;
  logic [3:0]   FREE_COUNT;

  int vectors     = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  // Reference model state: sensor sampling delay and a window of the
  // values the debouncer sees since the last reset.
  logic [N-1:0] m_s1, m_s2;
  logic [N-1:0] m_win[$];
  logic [N-1:0] m_occ, m_arr, m_dep, m_fault;
  int           m_aborts[N];

  always #5 clk = ~clk;

  park_slot_sensor_filter #(
    .NUM_SLOTS       (N),
    .DEBOUNCE_CYCLES (DEB),
    .CHATTER_LIMIT   (LIMIT)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .SENSOR     (sensor),
    .OCCUPIED   (OCCUPIED),
    .ARRIVE     (ARRIVE),
    .DEPART     (DEPART),
    .FREE_COUNT (FREE_COUNT),
    .FAULT      (FAULT)
  );

  // A slot changes when the last DEB+1 seen values all disagree with it;
  // an abort is a disagreeing value followed by an agreeing one.
  task automatic model_edge(input logic r, input logic [N-1:0] s);
    exp_t e;
    logic [N-1:0] seen;
    bit all_diff;
    if (r) begin
      m_s1 = '0; m_s2 = '0;
      m_win.delete();
      m_occ = '0; m_arr = '0; m_dep = '0; m_fault = '0;
      for (int i = 0; i < N; i++) m_aborts[i] = 0;
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = s;
      m_win.push_back(seen);
      if (m_win.size() > DEB + 1) void'(m_win.pop_front());
      m_arr = '0; m_dep = '0;
      for (int i = 0; i < N; i++) begin
        all_diff = (m_win.size() == DEB + 1);
        foreach (m_win[k]) if (m_win[k][i] == m_occ[i]) all_diff = 0;
        if (all_diff) begin
          if (m_occ[i]) m_dep[i] = 1'b1; else m_arr[i] = 1'b1;
          m_occ[i] = ~m_occ[i];
          m_aborts[i] = 0;
        end else if (m_win.size() >= 2 && m_win[m_win.size()-2][i] != m_occ[i]
                     && m_win[m_win.size()-1][i] == m_occ[i]) begin
          if (m_aborts[i] < 15) m_aborts[i]++;
          if (m_aborts[i] >= LIMIT) m_fault[i] = 1'b1;
        end
      end
    end
    e.occ  = m_occ;
    e.arr  = m_arr;
    e.dep  = m_dep;
    e.free = 4'(N - $countones(m_occ));
`ifdef CHATTER_FAULT_EN
    e.fault = m_fault;
`else
    e.fault = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic r, input logic [N-1:0] s);
    rst    = r;
    sensor = s;
    model_edge(r, s);
    @(posedge clk);
    #3;
  endtask

  task automatic hold(input logic [N-1:0] s, input int cycles);
    for (int k = 0; k < cycles; k++) apply(1'b0, s);
  endtask

  // Monitor: one expected entry per clock edge, checked 1 time unit later.
  initial begin
    exp_t e;
    bit bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        bad = 0;
        if (OCCUPIED !== e.occ) begin
          $display("FAIL occupied @%0t: got %b want %b", $time, OCCUPIED, e.occ); bad = 1;
        end
        if (ARRIVE !== e.arr) begin
          $display("FAIL arrive @%0t: got %b want %b", $time, ARRIVE, e.arr); bad = 1;
        end
        if (DEPART !== e.dep) begin
          $display("FAIL depart @%0t: got %b want %b", $time, DEPART, e.dep); bad = 1;
        end
        if (FREE_COUNT !== e.free) begin
          $display("FAIL free_count @%0t: got %0d want %0d", $time, FREE_COUNT, e.free); bad = 1;
        end
        if (FAULT !== e.fault) begin
          $display("FAIL fault @%0t: got %b want %b", $time, FAULT, e.fault); bad = 1;
        end
        vectors++;
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    logic [N-1:0] s;
    int guard;
    // Reset then idle.
    apply(1'b1, '0);
    apply(1'b1, '0);
    hold('0, 20);
    // Slot 0 arrival held.
    hold(6'b000001, 10);
    // Short glitch on slot 2.
    hold(6'b000101, 3);
    hold(6'b000001, 10);
    // All slots arrive at once, then slot 5 departs.
    apply(1'b1, '0);
    hold(6'b111111, 10);
    hold(6'b011111, 10);
    // Reset in the middle of a pending arrival on slot 1.
    apply(1'b1, '0);
    hold(6'b000010, 3);
    apply(1'b1, 6'b000010);
    hold('0, 10);
    hold(6'b000010, 10);
    // Chatter on slot 4: 2 high / 2 low, three times; fault clears on reset.
    apply(1'b1, '0);
    for (int k = 0; k < 3; k++) begin
      hold(6'b010000, 2);
      hold(6'b000000, 2);
    end
    hold('0, 10);
    apply(1'b1, '0);
    hold('0, 5);
    // Random sensor activity with occasional reset.
    s = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) s = s ^ (N'($urandom) & N'($urandom));
      apply($urandom_range(0, 399) == 0, s);
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
